// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and baud divider math.
// Used by both uart_tx and the UART receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Whole system clocks per line bit; callers must keep the result >= 2.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
// Held at zero while clear is high so the first bit after a request starts aligned.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap on the last count, which is also the bit boundary.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // tick is registered so it is high exactly while cnt_q sits on LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted request as an 8N1/8N2 frame, or 8E1/8E2
// when UART_TX_PARITY_EN is defined. Tx, ready and done all come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Din,
  input  logic       start,
  output logic       ready,
  output logic       Tx,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP    = 3'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]                state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_q, bit_d;
  logic                      tx_d, ready_d, done_d;
  logic                      tick;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // Divider only runs inside a frame; IDLE keeps it cleared.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = Tx;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (start && ready) begin
          shift_d = Din;
          bit_d   = '0;
          state_d = ST_START;
          tx_d    = ~UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
          parity_d = ^Din;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
`endif
      // bit_q counts stop bits here.
      ST_STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      Tx      <= UART_IDLE_LEVEL;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      Tx      <= tx_d;
      ready   <= ready_d;
      done    <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule
